// File: rtl/gray_stream_codec_if.sv
// Valid/ready stream bundle for the Gray codec: input beat side and converted output side.
interface gray_stream_codec_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_mode;
    logic             out_jump;

    modport master (
        output in_valid, in_data, in_mode, out_ready,
        input  in_ready, out_valid, out_data, out_mode, out_jump
    );

    modport slave (
        input  in_valid, in_data, in_mode, out_ready,
        output in_ready, out_valid, out_data, out_mode, out_jump
    );
endinterface

// File: rtl/gray_stream_codec.sv
// Pipelined Gray<->binary stream converter with valid/ready flow control
// and a monitor that flags non-unit steps between consecutive decoded beats.
module gray_stream_codec #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    gray_stream_codec_if.slave   bus,
    input  logic                 hist_clr,
    output logic [CNT_W-1:0]     jump_count
);
    // Decode is a log-depth suffix XOR; its shift steps are spread contiguously over the stages.
    localparam int unsigned NSTEPS = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned PER    = (NSTEPS + STAGES - 1) / STAGES;
    localparam int unsigned LAST   = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] mode_q;
    logic [WIDTH-1:0]  dat_q [STAGES];
    logic [WIDTH-1:0]  dat_d [STAGES];
    logic [WIDTH-1:0]  src   [STAGES];
    logic [STAGES-1:0] src_mode;
    logic              adv;
    logic              hs;
    logic [WIDTH-1:0]  x;
    logic              m;
    logic [WIDTH-1:0]  prev_val;
    logic              prev_ok;
    logic [WIDTH-1:0]  diff;

    assign adv          = !vld_q[LAST] || bus.out_ready;
    assign bus.in_ready = adv;
    assign bus.out_valid = vld_q[LAST];
    assign bus.out_data  = dat_q[LAST];
    assign bus.out_mode  = mode_q[LAST];
    assign hs            = vld_q[LAST] && bus.out_ready;

    // Stage inputs: the stream for stage 0, the previous stage register otherwise.
    always_comb begin
        src[0]      = bus.in_data;
        src_mode[0] = bus.in_mode;
        for (int unsigned s = 1; s < STAGES; s++) begin
            src[s]      = dat_q[s-1];
            src_mode[s] = mode_q[s-1];
        end
    end

    always_comb begin
        x = '0;
        m = 1'b0;
        for (int unsigned s = 0; s < STAGES; s++) begin
            x = src[s];
            m = src_mode[s];
            if (s == 0 && m) begin
                x = x ^ (x >> 1);
            end
            for (int unsigned k = 0; k < NSTEPS; k++) begin
                if (!m && (k / PER) == s) begin
                    x = x ^ (x >> (1 << k));
                end
            end
            dat_d[s] = x;
        end
    end

    // Whole pipeline advances together; a stall holds every stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            mode_q <= '0;
            for (int unsigned s = 0; s < STAGES; s++) begin
                dat_q[s] <= '0;
            end
        end else if (adv) begin
            vld_q[0]  <= bus.in_valid;
            mode_q[0] <= bus.in_mode;
            dat_q[0]  <= dat_d[0];
            for (int unsigned s = 1; s < STAGES; s++) begin
                vld_q[s]  <= vld_q[s-1];
                mode_q[s] <= mode_q[s-1];
                dat_q[s]  <= dat_d[s];
            end
        end
    end

    // Modular difference of 0, +1 or -1 is a normal counter step.
    assign diff         = dat_q[LAST] - prev_val;
    assign bus.out_jump = vld_q[LAST] && !mode_q[LAST] && prev_ok &&
                          !(diff == '0 || diff == WIDTH'(1) || diff == '1);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_val   <= '0;
            prev_ok    <= 1'b0;
            jump_count <= '0;
        end else begin
            if (hs && !mode_q[LAST]) begin
                prev_val <= dat_q[LAST];
            end
            if (hist_clr) begin
                prev_ok    <= 1'b0;
                jump_count <= '0;
            end else begin
                if (hs && !mode_q[LAST]) begin
                    prev_ok <= 1'b1;
                end
                if (hs && bus.out_jump && jump_count != '1) begin
                    jump_count <= jump_count + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_gray_stream_codec.sv
// Directed self-checking bench for gray_stream_codec at 16/2, 8/1 and 64/4 configurations.
module tb_gray_stream_codec;
    logic        clk;
    logic        rst;
    logic        hist_clr16, hist_clr8, hist_clr64;
    logic [15:0] jump_count16, jump_count8, jump_count64;
    int          n_checks;
    int          n_fail;

    gray_stream_codec_if #(.WIDTH(16)) bus16 ();
    gray_stream_codec_if #(.WIDTH(8))  bus8 ();
    gray_stream_codec_if #(.WIDTH(64)) bus64 ();

    gray_stream_codec #(.WIDTH(16), .STAGES(2), .CNT_W(16)) u16 (
        .clk(clk), .rst(rst), .bus(bus16), .hist_clr(hist_clr16), .jump_count(jump_count16)
    );
    gray_stream_codec #(.WIDTH(8), .STAGES(1), .CNT_W(16)) u8 (
        .clk(clk), .rst(rst), .bus(bus8), .hist_clr(hist_clr8), .jump_count(jump_count8)
    );
    gray_stream_codec #(.WIDTH(64), .STAGES(4), .CNT_W(16)) u64 (
        .clk(clk), .rst(rst), .bus(bus64), .hist_clr(hist_clr64), .jump_count(jump_count64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_checks++;
        if (bus16.out_valid !== 1'b0 || bus16.out_data !== 16'h0 || bus16.out_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b d=%h m=%b want v=0 d=0000 m=0",
                     bus16.out_valid, bus16.out_data, bus16.out_mode);
        end
        n_checks++;
        if (bus16.out_jump !== 1'b0 || jump_count16 !== 16'h0 || bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_monitor: got jump=%b cnt=%0d rdy=%b want 0 0 1",
                     bus16.out_jump, jump_count16, bus16.in_ready);
        end
    endtask

    task automatic test_decode();
        logic [15:0] vin [3];
        logic [15:0] vexp [3];
        vin  = '{16'h0007, 16'h8000, 16'hFFFF};
        vexp = '{16'h0005, 16'hFFFF, 16'hAAAA};
        for (int i = 0; i < 3; i++) begin
            bus16.in_valid = 1'b1;
            bus16.in_data  = vin[i];
            bus16.in_mode  = 1'b0;
            step();
            bus16.in_valid = 1'b0;
            n_checks++;
            if (bus16.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_early_%0d: out_valid=%b after 1 cycle, want 0", i, bus16.out_valid);
            end
            step();
            n_checks++;
            if (bus16.out_valid !== 1'b1 || bus16.out_data !== vexp[i] || bus16.out_mode !== 1'b0) begin
                n_fail++;
                $display("FAIL decode_%0d: got v=%b d=%h m=%b want v=1 d=%h m=0",
                         i, bus16.out_valid, bus16.out_data, bus16.out_mode, vexp[i]);
            end
        end
        step();
    endtask

    task automatic test_encode();
        logic [15:0] vin [2];
        logic [15:0] vexp [2];
        vin  = '{16'h0005, 16'hFFFF};
        vexp = '{16'h0007, 16'h8000};
        for (int i = 0; i < 2; i++) begin
            bus16.in_valid = 1'b1;
            bus16.in_data  = vin[i];
            bus16.in_mode  = 1'b1;
            step();
            bus16.in_valid = 1'b0;
            step();
            n_checks++;
            if (bus16.out_valid !== 1'b1 || bus16.out_data !== vexp[i] ||
                bus16.out_mode !== 1'b1 || bus16.out_jump !== 1'b0) begin
                n_fail++;
                $display("FAIL encode_%0d: got v=%b d=%h m=%b j=%b want v=1 d=%h m=1 j=0",
                         i, bus16.out_valid, bus16.out_data, bus16.out_mode, bus16.out_jump, vexp[i]);
            end
        end
        step();
    endtask

    task automatic test_mixed_modes();
        logic [15:0] vin [4];
        logic [15:0] vexp [4];
        logic        vmode [4];
        vin   = '{16'h0007, 16'h0005, 16'h8000, 16'hFFFF};
        vexp  = '{16'h0005, 16'h0007, 16'hFFFF, 16'h8000};
        vmode = '{1'b0, 1'b1, 1'b0, 1'b1};
        for (int c = 0; c < 5; c++) begin
            bus16.in_valid = (c < 4);
            bus16.in_data  = (c < 4) ? vin[c] : 16'h0;
            bus16.in_mode  = (c < 4) ? vmode[c] : 1'b0;
            step();
            if (c >= 1) begin
                n_checks++;
                if (bus16.out_valid !== 1'b1 || bus16.out_data !== vexp[c-1] ||
                    bus16.out_mode !== vmode[c-1]) begin
                    n_fail++;
                    $display("FAIL mixed_%0d: got v=%b d=%h m=%b want v=1 d=%h m=%b",
                             c - 1, bus16.out_valid, bus16.out_data, bus16.out_mode,
                             vexp[c-1], vmode[c-1]);
                end
            end
        end
        bus16.in_valid = 1'b0;
        step();
    endtask

    task automatic test_jump_monitor();
        logic [15:0] vin [5];
        logic [15:0] vexp [5];
        logic        vjump [5];
        hist_clr16 = 1'b1;
        step();
        hist_clr16 = 1'b0;
        n_checks++;
        if (jump_count16 !== 16'h0) begin
            n_fail++;
            $display("FAIL jump_clear: jump_count=%0d want 0", jump_count16);
        end
        // Gray codes of FFFE, FFFF, 0000, 0001, 0009.
        vin   = '{16'h8001, 16'h8000, 16'h0000, 16'h0001, 16'h000D};
        vexp  = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001, 16'h0009};
        vjump = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int c = 0; c < 6; c++) begin
            bus16.in_valid = (c < 5);
            bus16.in_data  = (c < 5) ? vin[c] : 16'h0;
            bus16.in_mode  = 1'b0;
            step();
            if (c >= 1) begin
                n_checks++;
                if (bus16.out_valid !== 1'b1 || bus16.out_data !== vexp[c-1] ||
                    bus16.out_jump !== vjump[c-1]) begin
                    n_fail++;
                    $display("FAIL jump_beat_%0d: got v=%b d=%h j=%b want v=1 d=%h j=%b",
                             c - 1, bus16.out_valid, bus16.out_data, bus16.out_jump,
                             vexp[c-1], vjump[c-1]);
                end
            end
            if (c == 4) begin
                n_checks++;
                if (jump_count16 !== 16'h0) begin
                    n_fail++;
                    $display("FAIL jump_wrap_count: jump_count=%0d want 0", jump_count16);
                end
            end
        end
        bus16.in_valid = 1'b0;
        step();
        n_checks++;
        if (jump_count16 !== 16'h1) begin
            n_fail++;
            $display("FAIL jump_count_one: jump_count=%0d want 1", jump_count16);
        end
    endtask

    task automatic test_hist_clr();
        // Gray(0x0100) follows decoded 0x0009: a jump.
        bus16.in_valid = 1'b1;
        bus16.in_data  = 16'h0180;
        bus16.in_mode  = 1'b0;
        step();
        bus16.in_valid = 1'b0;
        step();
        hist_clr16 = 1'b1;
        n_checks++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'h0100 || bus16.out_jump !== 1'b1) begin
            n_fail++;
            $display("FAIL clr_jump_beat: got v=%b d=%h j=%b want v=1 d=0100 j=1",
                     bus16.out_valid, bus16.out_data, bus16.out_jump);
        end
        step();
        hist_clr16 = 1'b0;
        n_checks++;
        if (jump_count16 !== 16'h0) begin
            n_fail++;
            $display("FAIL clr_count: jump_count=%0d want 0", jump_count16);
        end
        // Gray(0x5000): far from 0x0100 but history was cleared.
        bus16.in_valid = 1'b1;
        bus16.in_data  = 16'h7800;
        step();
        bus16.in_valid = 1'b0;
        step();
        n_checks++;
        if (bus16.out_valid !== 1'b1 || bus16.out_data !== 16'h5000 || bus16.out_jump !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_next_beat: got v=%b d=%h j=%b want v=1 d=5000 j=0",
                     bus16.out_valid, bus16.out_data, bus16.out_jump);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [15:0] vin [8];
        logic [15:0] vexp [8];
        logic [31:0] pat;
        logic        acc;
        logic        hs;
        int          snd;
        int          rcv;
        int          cyc;
        vin  = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h00FF, 16'h1234, 16'hAAAA, 16'h8000};
        vexp = '{16'h0001, 16'h0003, 16'h0002, 16'h0006, 16'h0080, 16'h1B2E, 16'hFFFF, 16'hC000};
        pat  = 32'hB5A3_6C9D;
        snd  = 0;
        rcv  = 0;
        cyc  = 0;
        while (rcv < 8 && cyc < 200) begin
            bus16.out_ready = pat[cyc % 32];
            bus16.in_valid  = (snd < 8);
            bus16.in_data   = (snd < 8) ? vin[snd] : 16'h0;
            bus16.in_mode   = 1'b1;
            #1;
            n_checks++;
            if (bus16.in_ready !== (!bus16.out_valid || bus16.out_ready)) begin
                n_fail++;
                $display("FAIL bp_in_ready cyc %0d: got %b want %b", cyc, bus16.in_ready,
                         !bus16.out_valid || bus16.out_ready);
            end
            if (bus16.out_valid === 1'b1) begin
                n_checks++;
                if (bus16.out_data !== vexp[rcv]) begin
                    n_fail++;
                    $display("FAIL bp_data cyc %0d beat %0d: got %h want %h",
                             cyc, rcv, bus16.out_data, vexp[rcv]);
                end
            end
            acc = bus16.in_valid && bus16.in_ready;
            hs  = bus16.out_valid && bus16.out_ready;
            step();
            if (acc) snd++;
            if (hs) rcv++;
            cyc++;
        end
        bus16.in_valid  = 1'b0;
        bus16.out_ready = 1'b1;
        n_checks++;
        if (rcv != 8) begin
            n_fail++;
            $display("FAIL bp_delivered: got %0d beats want 8", rcv);
        end
        step();
        step();
        n_checks++;
        if (bus16.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_no_dup: out_valid=%b after drain, want 0", bus16.out_valid);
        end
    endtask

    task automatic test_reset_in_flight();
        bus16.in_valid = 1'b1;
        bus16.in_mode  = 1'b0;
        bus16.in_data  = 16'h0033;
        step();
        bus16.in_data  = 16'h0044;
        step();
        bus16.in_valid = 1'b0;
        rst = 1'b1;
        step();
        n_checks++;
        if (bus16.out_valid !== 1'b0 || jump_count16 !== 16'h0 || bus16.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush16: got v=%b cnt=%0d rdy=%b want 0 0 1",
                     bus16.out_valid, jump_count16, bus16.in_ready);
        end
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            n_checks++;
            if (bus16.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush16_ghost cyc %0d: out_valid=%b want 0", c, bus16.out_valid);
            end
        end
    endtask

    task automatic test_latency_w8();
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h80;
        bus8.in_mode  = 1'b0;
        step();
        bus8.in_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            n_checks++;
            if (bus8.out_valid !== 1'(c == 1)) begin
                n_fail++;
                $display("FAIL lat8_valid cyc %0d: got %b want %b", c, bus8.out_valid, c == 1);
            end
            if (c == 1) begin
                n_checks++;
                if (bus8.out_data !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL lat8_data: got %h want ff", bus8.out_data);
                end
            end
            step();
        end
        bus8.in_valid = 1'b1;
        bus8.in_data  = 8'h11;
        step();
        bus8.in_data  = 8'h22;
        step();
        bus8.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || jump_count8 !== 16'h0) begin
            n_fail++;
            $display("FAIL flush8: got v=%b rdy=%b cnt=%0d want 0 1 0",
                     bus8.out_valid, bus8.in_ready, jump_count8);
        end
        for (int c = 0; c < 3; c++) begin
            step();
            n_checks++;
            if (bus8.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush8_ghost cyc %0d: out_valid=%b want 0", c, bus8.out_valid);
            end
        end
    endtask

    task automatic test_latency_w64();
        bus64.in_valid = 1'b1;
        bus64.in_data  = 64'h8000_0000_0000_0000;
        bus64.in_mode  = 1'b0;
        step();
        bus64.in_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            n_checks++;
            if (bus64.out_valid !== 1'(c == 4)) begin
                n_fail++;
                $display("FAIL lat64_valid cyc %0d: got %b want %b", c, bus64.out_valid, c == 4);
            end
            if (c == 4) begin
                n_checks++;
                if (bus64.out_data !== 64'hFFFF_FFFF_FFFF_FFFF) begin
                    n_fail++;
                    $display("FAIL lat64_data: got %h want ffffffffffffffff", bus64.out_data);
                end
            end
            step();
        end
        bus64.in_valid = 1'b1;
        bus64.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus64.in_mode  = 1'b0;
        step();
        bus64.in_data  = 64'h0000_0000_0000_0003;
        step();
        bus64.in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if (bus64.out_valid !== 1'b0 || bus64.in_ready !== 1'b1 || jump_count64 !== 16'h0) begin
            n_fail++;
            $display("FAIL flush64: got v=%b rdy=%b cnt=%0d want 0 1 0",
                     bus64.out_valid, bus64.in_ready, jump_count64);
        end
        for (int c = 0; c < 6; c++) begin
            step();
            n_checks++;
            if (bus64.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush64_ghost cyc %0d: out_valid=%b want 0", c, bus64.out_valid);
            end
        end
        bus64.in_valid = 1'b1;
        bus64.in_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        bus64.in_mode  = 1'b1;
        step();
        bus64.in_valid = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if (bus64.out_valid !== 1'b1 || bus64.out_data !== 64'h8000_0000_0000_0000 ||
            bus64.out_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL enc64: got v=%b d=%h m=%b want v=1 d=8000000000000000 m=1",
                     bus64.out_valid, bus64.out_data, bus64.out_mode);
        end
        step();
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst             = 1'b1;
        hist_clr16      = 1'b0;
        hist_clr8       = 1'b0;
        hist_clr64      = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.in_data   = '0;
        bus16.in_mode   = 1'b0;
        bus16.out_ready = 1'b1;
        bus8.in_valid   = 1'b0;
        bus8.in_data    = '0;
        bus8.in_mode    = 1'b0;
        bus8.out_ready  = 1'b1;
        bus64.in_valid  = 1'b0;
        bus64.in_data   = '0;
        bus64.in_mode   = 1'b0;
        bus64.out_ready = 1'b1;

        test_reset();
        test_decode();
        test_encode();
        test_mixed_modes();
        test_jump_monitor();
        test_hist_clr();
        test_back_to_back();
        test_reset_in_flight();
        test_latency_w8();
        test_latency_w64();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
